// File: rtl/fifo_muestras_multicanal.sv
// fifo_muestras_multicanal: frame-aware multichannel sample buffer.
// An Avalon-ST sink writes tagged samples; only complete N_CH-channel frames
// become visible. An Avalon-MM slave pops samples through a show-ahead head
// register and exposes fill level, discard counters and control bits.
//
// Handshake semantics: the sink takes a beat on every clock edge where
// avalonst_sink_valid=1 (ready is 1 whenever out of reset and is never used
// for back-pressure; frames that cannot be stored are dropped instead). On the
// slave side a read or write completes on the edge where it is asserted and
// waitrequest=0; only pops of an empty-headed, non-empty FIFO ever stall.
module fifo_muestras_multicanal #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int N_CH       = 8,
    parameter int CH_W       = 3
) (
    input  logic              wrclock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] avalonst_sink_data,
    input  logic [CH_W-1:0]   avalonst_sink_channel,
    input  logic              avalonst_sink_valid,
    output logic              avalonst_sink_ready,
    input  logic [1:0]        avalonmm_slave_address,
    input  logic              avalonmm_slave_read,
    input  logic              avalonmm_slave_write,
    input  logic [DATA_W-1:0] avalonmm_slave_writedata,
    output logic [DATA_W-1:0] avalonmm_slave_readdata,
    output logic              avalonmm_slave_waitrequest
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] NCH_LVL   = LVL_W'(N_CH);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);
    localparam logic [CH_W-1:0]  FIRST_CH  = CH_W'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DROP = 2'd2
    } frame_state_t;

    // Frame assembly state
    frame_state_t            state, state_nx;
    logic [CH_W-1:0]         exp_ch, exp_ch_nx;
    logic [DEPTH_LOG2-1:0]   wr_spec, wr_spec_nx;
    logic [DEPTH_LOG2-1:0]   wr_com, wr_com_nx;

    // Read side state
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [LVL_W-1:0]        level;
    logic [DATA_W-1:0]       head;
    logic                    head_valid;
    logic                    fetch_pend;
    logic [DATA_W-1:0]       ram_q;

    // Statistics
    logic [15:0]             drop_cnt;
    logic [15:0]             seq_err;
    logic                    overflow;
    logic                    underflow;

    // Storage
    logic [DATA_W-1:0]       mem [DEPTH];

    // Per-cycle decodes
    logic                    ram_we;
    logic [DEPTH_LOG2-1:0]   ram_wa;
    logic                    commit;
    logic                    seq_inc;
    logic                    drop_inc;
    logic                    ovf_set;
    logic                    start;
    logic                    beat;
    logic                    rd0;
    logic                    pop;
    logic                    empty_rd;
    logic                    wr3;
    logic                    flush;
    logic                    clr;
    logic [LVL_W-1:0]        free;
    logic                    fits;
    logic [LVL_W-1:0]        unfetched;
    logic                    fetch;
    logic                    unused_bits;

    assign avalonst_sink_ready = reset_n;

    assign beat     = avalonst_sink_valid;
    assign rd0      = avalonmm_slave_read && (avalonmm_slave_address == 2'd0);
    assign pop      = rd0 && head_valid;
    assign empty_rd = rd0 && (level == '0);
    assign wr3      = avalonmm_slave_write && (avalonmm_slave_address == 2'd3);
    assign flush    = wr3 && avalonmm_slave_writedata[0];
    assign clr      = wr3 && avalonmm_slave_writedata[1];
    assign free     = DEPTH_LVL - level;
    assign fits     = (free >= NCH_LVL);

    assign avalonmm_slave_waitrequest = rd0 && (level != '0) && !head_valid;

    // Words committed but neither in the head register nor in flight from RAM.
    assign unfetched = level - LVL_W'(head_valid) - LVL_W'(fetch_pend);
    // Fetch when the head slot is (or is about to become) free and no read is in flight.
    assign fetch     = (!head_valid || pop) && !fetch_pend && (unfetched != '0) && !flush;

    assign unused_bits = ^avalonmm_slave_writedata[DATA_W-1:2];

    // Frame FSM: next state, speculative/committed pointers and counter events
    always_comb begin
        state_nx   = state;
        exp_ch_nx  = exp_ch;
        wr_spec_nx = wr_spec;
        wr_com_nx  = wr_com;
        ram_we     = 1'b0;
        ram_wa     = wr_spec;
        commit     = 1'b0;
        seq_inc    = 1'b0;
        drop_inc   = 1'b0;
        ovf_set    = 1'b0;
        start      = 1'b0;
        if (beat) begin
            case (state)
                S_IDLE: begin
                    if (avalonst_sink_channel == FIRST_CH) begin
                        start = 1'b1;
                    end else begin
                        seq_inc  = 1'b1;
                        state_nx = S_DROP;
                    end
                end
                S_FILL: begin
                    if (avalonst_sink_channel == exp_ch) begin
                        ram_we     = 1'b1;
                        ram_wa     = wr_spec;
                        wr_spec_nx = wr_spec + 1'b1;
                        if (exp_ch == LAST_CH) begin
                            commit    = 1'b1;
                            wr_com_nx = wr_spec + 1'b1;
                            state_nx  = S_IDLE;
                        end else begin
                            exp_ch_nx = exp_ch + CH_W'(1);
                        end
                    end else if (avalonst_sink_channel == FIRST_CH) begin
                        // Restart: abandon the partial frame and reuse this beat as a new start.
                        seq_inc    = 1'b1;
                        wr_spec_nx = wr_com;
                        start      = 1'b1;
                    end else begin
                        seq_inc    = 1'b1;
                        wr_spec_nx = wr_com;
                        state_nx   = S_DROP;
                    end
                end
                S_DROP: begin
                    if (avalonst_sink_channel == FIRST_CH) begin
                        start = 1'b1;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
        // A frame start always writes from the committed pointer.
        if (start) begin
            if (fits) begin
                ram_we     = 1'b1;
                ram_wa     = wr_com;
                wr_spec_nx = wr_com + 1'b1;
                if (N_CH == 1) begin
                    commit    = 1'b1;
                    wr_com_nx = wr_com + 1'b1;
                    state_nx  = S_IDLE;
                end else begin
                    exp_ch_nx = CH_W'(1);
                    state_nx  = S_FILL;
                end
            end else begin
                drop_inc = 1'b1;
                ovf_set  = 1'b1;
                state_nx = S_DROP;
            end
        end
    end

    // Frame FSM state register and write pointers; flush returns to an empty IDLE
    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            exp_ch  <= '0;
            wr_spec <= '0;
            wr_com  <= '0;
        end else if (flush) begin
            state   <= S_IDLE;
            exp_ch  <= '0;
            wr_spec <= '0;
            wr_com  <= '0;
        end else begin
            state   <= state_nx;
            exp_ch  <= exp_ch_nx;
            wr_spec <= wr_spec_nx;
            wr_com  <= wr_com_nx;
        end
    end

    // Sample RAM with registered read port feeding the head register
    always_ff @(posedge wrclock) begin
        if (ram_we && !flush) begin
            mem[ram_wa] <= avalonst_sink_data;
        end
        if (fetch) begin
            ram_q <= mem[rd_ptr];
        end
    end

    // Read pointer, fetch tracking and show-ahead head register
    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            head       <= '0;
            head_valid <= 1'b0;
            fetch_pend <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            fetch_pend <= 1'b0;
        end else begin
            if (fetch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fetch_pend <= fetch;
            if (fetch_pend) begin
                head       <= ram_q;
                head_valid <= 1'b1;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
        end
    end

    // Committed fill level: commits add a whole frame, pops remove one word
    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else begin
            level <= level + (commit ? NCH_LVL : '0) - LVL_W'(pop);
        end
    end

    // Saturating discard counters and sticky flags
    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt  <= '0;
            seq_err   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush || clr) begin
            drop_cnt  <= '0;
            seq_err   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (seq_inc && (seq_err != 16'hFFFF)) begin
                seq_err <= seq_err + 16'd1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (empty_rd) begin
                underflow <= 1'b1;
            end
        end
    end

    // Register read mux; an empty pop returns zero
    always_comb begin
        avalonmm_slave_readdata = '0;
        if (avalonmm_slave_read) begin
            case (avalonmm_slave_address)
                2'd0: avalonmm_slave_readdata = head_valid ? head : '0;
                2'd1: avalonmm_slave_readdata = DATA_W'(level);
                2'd2: avalonmm_slave_readdata = DATA_W'({seq_err, drop_cnt});
                2'd3: avalonmm_slave_readdata = DATA_W'({underflow, overflow,
                                                         level == '0, level == DEPTH_LVL});
                default: avalonmm_slave_readdata = '0;
            endcase
        end
    end

endmodule
